// File: rtl/keypad_pkg.sv
// Shared types, constants and key-code helpers for the keypad debounce front end.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        LOCKOUT  = 3'd3,
        RELEASE  = 3'd4
    } state_e;

    localparam int KEY_CODE_W     = 4;
    localparam int N_KEYS_DEFAULT = 12;
    localparam int CODE_SPACE     = 1 << KEY_CODE_W;

    function automatic logic is_onehot(input logic [CODE_SPACE-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Lowest set line wins; only meaningful once is_onehot() has been confirmed.
    function automatic logic [KEY_CODE_W-1:0] prio_index(input logic [CODE_SPACE-1:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = CODE_SPACE - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_CODE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce_if.sv
// Keypad line input and key event outputs of the debounce stage.
interface keypad_debounce_if
    import keypad_pkg::*;
#(
    parameter int N_KEYS = N_KEYS_DEFAULT
);
    logic [N_KEYS-1:0]     keypad_in;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_err;
    logic                  key_held;
    state_e                dbg_state;

    // key_valid / key_err are single-cycle strobes with no back-pressure: the consumer
    // must take key_code in the cycle the strobe is high; key_code holds until the next press.
    modport master (
        output keypad_in,
        input  key_code, key_valid, key_err, key_held, dbg_state
    );

    modport slave (
        input  keypad_in,
        output key_code, key_valid, key_err, key_held, dbg_state
    );
endinterface

// File: rtl/keypad_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, synchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/keypad_debounce.sv
// Synchronises and debounces the raw keypad lines and emits one event per accepted press.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int N_KEYS    = N_KEYS_DEFAULT,
    parameter int DB_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_debounce_if.slave  kp
);
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] sync;

    sync_2ff #(.WIDTH(N_KEYS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.keypad_in),
        .q   (sync)
    );

    state_e                state_q,     state_d;
    state_e                origin_q,    origin_d;
    logic [N_KEYS-1:0]     cand_q,      cand_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [KEY_CODE_W-1:0] key_code_q,  key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_err_q,   key_err_d;
    logic                  key_held_q,  key_held_d;

    logic [CODE_SPACE-1:0] cand_ext;
    assign cand_ext = CODE_SPACE'(cand_q);

    always_comb begin
        state_d     = state_q;
        origin_d    = origin_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_err_d   = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            IDLE: begin
                if (sync != '0) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (sync == '0) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (is_onehot(cand_ext)) begin
                    key_code_d  = prio_index(cand_ext);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = PRESSED;
                end else begin
                    key_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = LOCKOUT;
                end
            end

            // Only an all-zero line set can leave a held or locked-out key.
            PRESSED, LOCKOUT: begin
                if (sync == '0) begin
                    cnt_d    = '0;
                    origin_d = state_q;
                    state_d  = RELEASE;
                end
            end

            RELEASE: begin
                if (sync != '0) begin
                    cnt_d   = '0;
                    state_d = origin_q;
                end else if (cnt_q == CNT_LAST) begin
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            origin_q    <= PRESSED;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_q    <= origin_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_err   = key_err_q;
    assign kp.key_held  = key_held_q;
    assign kp.dbg_state = state_q;
endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce: event scoreboard plus level checks on key_held/key_code.
module tb_keypad_debounce;
    import keypad_pkg::*;

    localparam int N   = 12;
    localparam int DB  = 4;
    localparam int W   = 32;
    localparam int LAT = DB + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_debounce_if #(.N_KEYS(N)) kp ();

    keypad_debounce #(.N_KEYS(N), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Expected events: {edge number the pulse follows[26:0], err, code[3:0]}
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [N-1:0] v);
        kp.keypad_in = v;
    endtask

    task automatic expect_event(input logic err, input logic [3:0] code);
        exp_q.push_back({27'(cyc + LAT), err, code});
    endtask

    task automatic release_and_check(input string tag);
        drive('0);
        tick(LAT - 1);
        check({tag, "_held_before_release"}, 32'(kp.key_held), 32'd1);
        tick(1);
        check({tag, "_held_after_release"}, 32'(kp.key_held), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1 || kp.key_err === 1'b1) begin
            check("valid_err_exclusive", 32'(kp.key_valid & kp.key_err), 32'd0);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_event observed=cyc%0d err%0b code%0d expected=none",
                       cyc, kp.key_err, kp.key_code);
            end
            if (exp_q.size() > 0) begin
                logic [W-1:0] exp;
                exp = exp_q.pop_front();
                check("event", {27'(cyc), kp.key_err, kp.key_code}, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(12'h040);
        tick(1);
        check("reset_outputs_0", {kp.key_code, kp.key_valid, kp.key_err, kp.key_held}, 32'd0);
        tick(1);
        check("reset_outputs_1", {kp.key_code, kp.key_valid, kp.key_err, kp.key_held}, 32'd0);
        check("reset_state", 32'(kp.dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Key held through reset is debounced afresh once reset drops.
        expect_event(1'b0, 4'd6);
        tick(LAT);
        check("post_reset_code", 32'(kp.key_code), 32'd6);
        release_and_check("post_reset");
        tick(2);

        // Clean press; release 20 cycles after the press.
        drive(12'h008);
        expect_event(1'b0, 4'd3);
        tick(LAT - 1);
        check("clean_no_early_valid", 32'(kp.key_valid), 32'd0);
        tick(1);
        check("clean_valid", 32'(kp.key_valid), 32'd1);
        check("clean_code", 32'(kp.key_code), 32'd3);
        check("clean_held", 32'(kp.key_held), 32'd1);
        tick(20 - LAT);
        release_and_check("clean");
        tick(2);

        // Bouncing contact, then stable.
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 12'h001 : 12'h000);
            tick(1);
        end
        drive(12'h001);
        expect_event(1'b0, 4'd0);
        tick(LAT);
        check("bounce_code", 32'(kp.key_code), 32'd0);
        check("bounce_held", 32'(kp.key_held), 32'd1);
        tick(3);
        release_and_check("bounce");
        tick(2);

        // Two keys at once: error, then changes without full release are ignored.
        drive(12'h005);
        expect_event(1'b1, 4'd0);
        tick(LAT);
        check("multi_err", 32'(kp.key_err), 32'd1);
        check("multi_valid", 32'(kp.key_valid), 32'd0);
        check("multi_held", 32'(kp.key_held), 32'd0);
        drive(12'h004);
        tick(12);
        drive(12'h00F);
        tick(12);
        check("lockout_held", 32'(kp.key_held), 32'd0);
        check("lockout_state", 32'(kp.dbg_state), 32'(LOCKOUT));
        drive('0);
        tick(LAT + 2);
        check("lockout_released_state", 32'(kp.dbg_state), 32'(IDLE));

        // Held key with a second key rolled on and off: no second event.
        drive(12'h100);
        expect_event(1'b0, 4'd8);
        tick(LAT);
        check("held_code", 32'(kp.key_code), 32'd8);
        tick(3);
        drive(12'h300);
        tick(12);
        drive(12'h100);
        tick(12);
        check("rollover_code", 32'(kp.key_code), 32'd8);
        check("rollover_held", 32'(kp.key_held), 32'd1);
        release_and_check("rollover");
        tick(2);
        drive(12'h800);
        expect_event(1'b0, 4'd11);
        tick(LAT);
        check("new_press_code", 32'(kp.key_code), 32'd11);
        release_and_check("new_press");
        tick(2);

        // Reset in the middle of a debounce count.
        drive(12'h020);
        tick(5);
        check("mid_debounce_state", 32'(kp.dbg_state), 32'(DEBOUNCE));
        rst = 1'b1;
        tick(1);
        check("mid_rst_outputs", {kp.key_code, kp.key_valid, kp.key_err, kp.key_held}, 32'd0);
        check("mid_rst_state", 32'(kp.dbg_state), 32'(IDLE));
        rst = 1'b0;
        expect_event(1'b0, 4'd5);
        tick(LAT);
        check("after_rst_code", 32'(kp.key_code), 32'd5);
        release_and_check("after_rst");

        tick(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
